// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state FSM encoding and framing constants.
// The transmitter and the receiver both import this package.
package uart_pkg;

  localparam int   DATA_BITS            = 8;
  localparam int   FRAME_BITS           = 10;
  localparam int   DEFAULT_CLKS_PER_BIT = 5208;
  localparam logic LINE_IDLE            = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producing client and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
// Shared by the UART transmitter and receiver.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == TERMINAL);

  // Restarting at terminal count keeps every bit exactly CLKS_PER_BIT long.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as an 8N1 frame on tx.
// tx and done are registered so the pin never sees combinational glitches.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state, state_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [IDX_W-1:0]     bit_idx, idx_next;
  logic                 tx_next;
  logic                 done_next;
  logic                 timer_clear;
  logic                 timer_en;
  logic                 tick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .tick   (tick)
  );

  assign bus.ready   = (state == IDLE);
  assign timer_en    = (state != IDLE);
  assign timer_clear = (state == IDLE);

  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    idx_next   = bit_idx;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.valid) begin
          shift_next = bus.data;
          idx_next   = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
          idx_next   = bit_idx + IDX_W'(1);
          if (bit_idx == LAST_IDX) state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is derived from the state being entered so it changes on the same edge.
  always_comb begin
    tx_next = LINE_IDLE;
    unique case (state_next)
      IDLE:    tx_next = LINE_IDLE;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      STOP:    tx_next = 1'b1;
      default: tx_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_idx <= '0;
      tx      <= LINE_IDLE;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      bit_idx <= idx_next;
      tx      <= tx_next;
      done    <= done_next;
    end
  end

  // Payload only matters once loaded on a handshake, so it carries no reset.
  always_ff @(posedge clk) begin
    shift_reg <= shift_next;
  end

endmodule
